// File: rtl/byte_striping.sv
// Two-lane transmit striper: even words go to lane_0, odd words to lane_1, and each
// pair is presented together; a lone even word is flushed on lane_0 after an idle timeout.
module byte_striping #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    output logic [31:0] lane_0,
    output logic        valid_0,
    output logic [31:0] lane_1,
    output logic        valid_1,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_EVEN = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // TIMEOUT of 0 disables flushing; the compare value is then irrelevant.
    localparam logic       FLUSH_EN  = (TIMEOUT != 0);
    localparam logic [7:0] IDLE_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [31:0] held_r;
    logic [31:0] held_s;
    logic [7:0]  idle_cnt_r;
    logic [7:0]  idle_cnt_s;
    logic [31:0] lane_0_r;
    logic [31:0] lane_0_s;
    logic [31:0] lane_1_r;
    logic [31:0] lane_1_s;
    logic        valid_0_r;
    logic        valid_0_s;
    logic        valid_1_r;
    logic        valid_1_s;
    logic        busy_r;

    // Next-state and output-event decode; pairing takes priority over the timeout flush.
    always_comb begin
        state_s    = state_r;
        held_s     = held_r;
        idle_cnt_s = idle_cnt_r;
        lane_0_s   = lane_0_r;
        lane_1_s   = lane_1_r;
        valid_0_s  = 1'b0;
        valid_1_s  = 1'b0;
        case (state_r)
            ST_EVEN: begin
                if (valid_in) begin
                    held_s     = data_in;
                    idle_cnt_s = 8'd0;
                    state_s    = ST_HOLD;
                end else begin
                    state_s = ST_EVEN;
                end
            end
            ST_HOLD: begin
                if (valid_in) begin
                    lane_0_s  = held_r;
                    lane_1_s  = data_in;
                    valid_0_s = 1'b1;
                    valid_1_s = 1'b1;
                    state_s   = ST_EVEN;
                end else if (FLUSH_EN && (idle_cnt_r == IDLE_LAST)) begin
                    lane_0_s  = held_r;
                    valid_0_s = 1'b1;
                    state_s   = ST_EVEN;
                end else begin
                    // Saturate so a disabled timeout can never wrap into a flush.
                    if (idle_cnt_r != 8'hFF) begin
                        idle_cnt_s = idle_cnt_r + 8'd1;
                    end else begin
                        idle_cnt_s = idle_cnt_r;
                    end
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s    = ST_EVEN;
                idle_cnt_s = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_r    <= ST_EVEN;
            held_r     <= 32'd0;
            idle_cnt_r <= 8'd0;
            lane_0_r   <= 32'd0;
            lane_1_r   <= 32'd0;
            valid_0_r  <= 1'b0;
            valid_1_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            held_r     <= held_s;
            idle_cnt_r <= idle_cnt_s;
            lane_0_r   <= lane_0_s;
            lane_1_r   <= lane_1_s;
            valid_0_r  <= valid_0_s;
            valid_1_r  <= valid_1_s;
            busy_r     <= (state_s == ST_HOLD);
        end
    end

    assign lane_0  = lane_0_r;
    assign lane_1  = lane_1_r;
    assign valid_0 = valid_0_r;
    assign valid_1 = valid_1_r;
    assign busy    = busy_r;

endmodule

// File: doc/byte_striping.md
# byte_striping

Transmit-side striper for the two-lane link. It takes a single 32-bit word stream (`data_in`/`valid_in`) and distributes consecutive valid words onto `lane_0` (even words) and `lane_1` (odd words). Each pair is presented simultaneously on both lanes with per-lane valids, which is the lane format the byte un-striping block recombines. A programmable idle timeout flushes a lone trailing even word on `lane_0` alone.

## Interface
- `TIMEOUT`, default 4: number of consecutive idle cycles in HOLD before a lone even word is flushed. Range 0..255; 0 disables flushing.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset_L` input 1: synchronous, active-low reset.
- `valid_in` input 1: `data_in` carries a word this cycle. No backpressure; every valid word is accepted.
- `data_in` input 32: input word.
- `lane_0` output 32: even word of the pair, or the flushed lone word. Registered.
- `valid_0` output 1: `lane_0` valid this cycle. Registered, one-cycle pulse per output event.
- `lane_1` output 32: odd word of the pair. Registered.
- `valid_1` output 1: `lane_1` valid this cycle. Registered.
- `busy` output 1: high while an even word is held awaiting its odd partner (state HOLD).

## Operation
- States:
  - EVEN: no word held.
  - HOLD: even word in internal register `held`; 8-bit idle counter `idle_cnt`.
- EVEN, `valid_in`=1: capture `data_in` into `held`, clear `idle_cnt`, go to HOLD. Valids are 0 next cycle.
- EVEN, `valid_in`=0: stay in EVEN. Valids are 0.
- HOLD, `valid_in`=1:
  - `lane_0`<=`held`, `lane_1`<=`data_in`, `valid_0`<=1, `valid_1`<=1.
  - Go to EVEN.
- HOLD, `valid_in`=0, `TIMEOUT`≠0, `idle_cnt`==`TIMEOUT`-1:
  - Flush: `lane_0`<=`held`, `valid_0`<=1, `valid_1`<=0, `lane_1` holds its value.
  - Go to EVEN.
- HOLD, `valid_in`=0, otherwise: `idle_cnt` increments, saturating at 255. Stay in HOLD.
- Lane data registers change only on output events. Between events they hold their last value; valids are 0.
- Word order is strictly preserved: even word on `lane_0`, odd word on `lane_1`. After a flush, the next valid word is again even.
- `busy` = (state==HOLD), registered alongside the state.

## Timing
- Reset (`reset_L`=0 at a rising edge):
  - `lane_0`=0, `lane_1`=0, `valid_0`=0, `valid_1`=0, `busy`=0.
  - State EVEN, `held`=0, `idle_cnt`=0.
- Reset has priority over every other event. Asserting it mid-pair discards the held word silently; no flush and no output pulse.
- Pair latency: the odd word accepted at edge N appears on both lanes with valids high after edge N (visible in cycle N+1). The even word therefore appears 1 + gap cycles after its own acceptance.
- Back-to-back input (`valid_in` high every cycle): one pair every 2 cycles. Valids alternate 1,0,1,0 with both lanes pulsing together.
- Flush timing: even word accepted at edge N, `valid_in` low for `TIMEOUT` cycles. At edge N+`TIMEOUT`, `valid_0`=1, `valid_1`=0, `busy`=0.
- Simultaneous events: a valid word in the cycle the timeout would fire forms a pair. Pairing has priority over flush.
- `TIMEOUT`=0: HOLD waits indefinitely. `idle_cnt` saturates without wrapping, so there is no spurious flush.
- The un-striper consumes `lane_0` and `lane_1` in the same cycle. Both valids of a pair must never be separated by even one cycle.

## Test plan
- Reset: hold `reset_L`=0 for 2 cycles with `valid_in`=1 and `data_in`=32'hFFFFFFFF. Required: all outputs 0, `busy`=0, and no valid pulse after release.
- Pairing: back-to-back words 32'h00000001..32'h00000006. Required: three pairs (1,2), (3,4), (5,6) on (`lane_0`,`lane_1`), each with both valids high for one cycle, the first one cycle after word 2 is accepted, pairs every 2 cycles.
- Gapped pair: 32'hAAAA0000, 3 idle cycles, then 32'hBBBB1111 (`TIMEOUT`=4). Required: `busy` high for 4 cycles, then `lane_0`=32'hAAAA0000, `lane_1`=32'hBBBB1111, both valids pulse once, no flush.
- Flush: 32'hDEADBEEF, then idle (`TIMEOUT`=4). Required: 4 cycles after acceptance, `valid_0`=1 with `lane_0`=32'hDEADBEEF, `valid_1`=0, `lane_1` unchanged. The next word 32'h12345678 is held as even.
- Race: 32'hC0C0C0C0, 3 idle cycles, 32'h0D0D0D0D in the 4th cycle (`TIMEOUT`=4). Required: a pair is emitted and no lone flush occurs. Also `TIMEOUT`=0 with 300 idle cycles: no output pulse, `busy` stays 1.
- Mid-pair reset: 32'h11111111 accepted, reset 1 cycle, then 32'h22222222, 32'h33333333. Required: a single pair (22222222, 33333333); 32'h11111111 never appears on either lane.
